// File: rtl/snax_hwpe_periph_regfile.sv
// -----------------------------------------------------------------------------
// snax_hwpe_periph_regfile
//
// Slave end of the 32-bit HWPE periph bus. Holds the accelerator job
// configuration registers, runs the job FSM (IDLE -> START -> RUNNING) and
// answers every granted access with a one-cycle response carrying the id.
//
// Optional feature macro: SNAX_HWPE_PERIPH_PERF_EN
//   defined   : PERF (word offset 0x0C) is a 32-bit busy-cycle counter
//   undefined : PERF reads 0 and no counter flops are built
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   periph_req_i         request, held until granted
//   periph_gnt_o         grant (combinational)
//   periph_add_i         byte address, word index = add[31:2]
//   periph_wen_i         1 = read, 0 = write
//   periph_be_i          byte enables (writes)
//   periph_data_i        write data
//   periph_id_i          transaction id
//   periph_r_data_o      read data (0 for write responses)
//   periph_r_valid_o     response valid, one cycle after the grant
//   periph_r_id_o        id echoed with the response
//   cfg_o                flattened config registers, reg0 in the LSBs
//   start_o              one-cycle job start pulse (state START)
//   clear_o              one-cycle datapath clear pulse
//   done_i               datapath job-complete pulse
//   evt_o                one-cycle completion event
//
// Register map (byte offsets)
//   0x00 TRIGGER    WO   0x04 STATUS RO   0x08 SOFT_CLEAR WO   0x0C PERF RO
//   0x10 + 4*i      CFG i RW (per-byte)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module snax_hwpe_periph_regfile #(
  parameter int unsigned NumRegs      = 8,
  parameter int unsigned IdWidth      = 5,
  parameter int unsigned DoneCntWidth = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    periph_req_i,
  output logic                    periph_gnt_o,
  input  logic [31:0]             periph_add_i,
  input  logic                    periph_wen_i,
  input  logic [3:0]              periph_be_i,
  input  logic [31:0]             periph_data_i,
  input  logic [IdWidth-1:0]      periph_id_i,
  output logic [31:0]             periph_r_data_o,
  output logic                    periph_r_valid_o,
  output logic [IdWidth-1:0]      periph_r_id_o,
  output logic [NumRegs*32-1:0]   cfg_o,
  output logic                    start_o,
  output logic                    clear_o,
  input  logic                    done_i,
  output logic                    evt_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    RUNNING = 2'd2
  } state_e;

  localparam logic [29:0] IdxTrigger = 30'd0;
  localparam logic [29:0] IdxStatus  = 30'd1;
  localparam logic [29:0] IdxClear   = 30'd2;
  localparam logic [29:0] IdxPerf    = 30'd3;
  localparam logic [29:0] IdxCfgBase = 30'd4;

  state_e                  state_reg, state_next;
  logic                    busy;
  logic                    start;

  logic                    rsp_pend_reg;
  logic [31:0]             r_data_reg;
  logic [IdWidth-1:0]      r_id_reg;
  logic                    evt_reg;
  logic                    clear_reg;
  logic                    err_reg;
  logic [DoneCntWidth-1:0] done_cnt_reg;

  logic [29:0]             word_idx;
  logic                    unused_addr_lsb;
  logic                    gnt;
  logic                    wr_acc, rd_acc, be_any;
  logic                    is_trigger, is_status, is_clear, is_perf, is_cfg;
  logic [NumRegs-1:0]      cfg_hit;
  logic [31:0]             cfg_word [NumRegs];
  logic                    soft_clear, trig_hit, trig_ok, trig_rej;
  logic                    cfg_wr_ok, cfg_rej, done_hit;
  logic [31:0]             status_word, perf_val, rd_val;

  // ---------------------------------------------------------------------------
  // Bus decode and handshake
  // ---------------------------------------------------------------------------
  assign word_idx        = periph_add_i[31:2];
  assign unused_addr_lsb = ^periph_add_i[1:0];

  // The response slot occupies the cycle after a grant, so no grant then.
  assign gnt          = periph_req_i & ~rsp_pend_reg;
  assign periph_gnt_o = gnt;

  assign wr_acc = gnt & ~periph_wen_i;
  assign rd_acc = gnt &  periph_wen_i;
  assign be_any = |periph_be_i;

  assign is_trigger = (word_idx == IdxTrigger);
  assign is_status  = (word_idx == IdxStatus);
  assign is_clear   = (word_idx == IdxClear);
  assign is_perf    = (word_idx == IdxPerf);
  assign is_cfg     = |cfg_hit;

  assign soft_clear = wr_acc & is_clear & be_any;
  assign trig_hit   = wr_acc & is_trigger & be_any;
  assign trig_ok    = trig_hit & ~busy;
  assign trig_rej   = trig_hit &  busy;
  assign cfg_wr_ok  = wr_acc & is_cfg & be_any & ~busy;
  assign cfg_rej    = wr_acc & is_cfg & be_any &  busy;
  // A soft clear wins over a completion arriving in the same cycle.
  assign done_hit   = done_i & (state_reg == RUNNING) & ~soft_clear;

  // ---------------------------------------------------------------------------
  // Configuration registers
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NumRegs; gi++) begin : g_cfg
      logic [31:0] data_reg;

      assign cfg_hit[gi] = (word_idx == IdxCfgBase + 30'(gi));

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          data_reg <= '0;
        end else if (soft_clear) begin
          data_reg <= '0;
        end else if (cfg_wr_ok && cfg_hit[gi]) begin
          for (int b = 0; b < 4; b++) begin
            if (periph_be_i[b]) begin
              data_reg[8*b +: 8] <= periph_data_i[8*b +: 8];
            end
          end
        end
      end

      assign cfg_word[gi]        = data_reg;
      assign cfg_o[gi*32 +: 32]  = data_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Job FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (trig_ok) state_next = START;
      START:   state_next = RUNNING;
      RUNNING: if (done_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (soft_clear) state_next = IDLE;
  end

  always_comb begin
    start = 1'b0;
    busy  = 1'b0;
    case (state_reg)
      START:   begin start = 1'b1; busy = 1'b1; end
      RUNNING: busy = 1'b1;
      default: ;
    endcase
  end

  assign start_o = start;

  // ---------------------------------------------------------------------------
  // Status bookkeeping and pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_reg      <= 1'b0;
      done_cnt_reg <= '0;
      evt_reg      <= 1'b0;
      clear_reg    <= 1'b0;
    end else begin
      evt_reg   <= done_hit;
      clear_reg <= soft_clear;
      if (soft_clear) begin
        err_reg      <= 1'b0;
        done_cnt_reg <= '0;
      end else begin
        if (trig_rej || cfg_rej) err_reg <= 1'b1;
        if (done_hit) done_cnt_reg <= done_cnt_reg + 1'b1;
      end
    end
  end

  assign evt_o   = evt_reg;
  assign clear_o = clear_reg;

`ifdef SNAX_HWPE_PERIPH_PERF_EN
  logic [31:0] perf_reg;

  // Restarts on an accepted trigger, counts every busy cycle, then holds.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_reg <= '0;
    end else if (soft_clear || trig_ok) begin
      perf_reg <= '0;
    end else if (busy) begin
      perf_reg <= perf_reg + 32'd1;
    end
  end

  assign perf_val = perf_reg;
`else
  assign perf_val = '0;
`endif

  // ---------------------------------------------------------------------------
  // Read mux and response
  // ---------------------------------------------------------------------------
  always_comb begin
    status_word                    = '0;
    status_word[0]                 = busy;
    status_word[1]                 = err_reg;
    status_word[8 +: DoneCntWidth] = done_cnt_reg;
  end

  always_comb begin
    rd_val = '0;
    if (is_status) rd_val = status_word;
    if (is_perf)   rd_val = perf_val;
    for (int i = 0; i < NumRegs; i++) begin
      if (cfg_hit[i]) rd_val = cfg_word[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_pend_reg <= 1'b0;
      r_data_reg   <= '0;
      r_id_reg     <= '0;
    end else begin
      rsp_pend_reg <= gnt;
      r_data_reg   <= rd_acc ? rd_val : 32'd0;
      r_id_reg     <= gnt ? periph_id_i : '0;
    end
  end

  assign periph_r_valid_o = rsp_pend_reg;
  assign periph_r_data_o  = r_data_reg;
  assign periph_r_id_o    = r_id_reg;

endmodule

// File: tb/tb_snax_hwpe_periph_regfile.sv
`timescale 1ns/1ps

module tb_snax_hwpe_periph_regfile;

  logic         clk;
  logic         rst_n;
  logic         req;
  logic         gnt;
  logic [31:0]  add;
  logic         wen;
  logic [3:0]   be;
  logic [31:0]  wdata;
  logic [4:0]   id;
  logic [31:0]  r_data;
  logic         r_valid;
  logic [4:0]   r_id;
  logic [255:0] cfg;
  logic         start;
  logic         clear;
  logic         done;
  logic         evt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] rd;

  snax_hwpe_periph_regfile #(
    .NumRegs(8), .IdWidth(5), .DoneCntWidth(8)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .periph_req_i(req), .periph_gnt_o(gnt), .periph_add_i(add),
    .periph_wen_i(wen), .periph_be_i(be), .periph_data_i(wdata),
    .periph_id_i(id), .periph_r_data_o(r_data), .periph_r_valid_o(r_valid),
    .periph_r_id_o(r_id), .cfg_o(cfg), .start_o(start), .clear_o(clear),
    .done_i(done), .evt_o(evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One bus transaction; returns at the response cycle (+1ns).
  task automatic bus_access(input logic is_rd, input logic [31:0] addr, input logic [3:0] ben,
                            input logic [31:0] data, input logic [4:0] tid,
                            output logic [31:0] rdata);
    int waited;
    waited = 0;
    @(negedge clk);
    req = 1'b1; wen = is_rd; add = addr; be = ben; wdata = data; id = tid;
    #1;
    while (!gnt && waited < 8) begin
      @(negedge clk); #1;
      waited++;
    end
    check_val("grant", {31'b0, gnt}, 32'd1);
    check_val("rvalid_in_gnt_cycle", {31'b0, r_valid}, 32'd0);
    @(posedge clk); #1;
    req = 1'b0; wen = 1'b1; be = 4'h0; wdata = '0; add = '0;
    check_val("rvalid", {31'b0, r_valid}, 32'd1);
    check_val("rid", {27'b0, r_id}, {27'b0, tid});
    rdata = r_data;
    if (!is_rd) check_val("wr_rdata_zero", r_data, 32'd0);
    $display("%0t %s addr=0x%08h be=0x%h wdata=0x%08h id=%0d rdata=0x%08h",
             $time, is_rd ? "RD" : "WR", addr, ben, data, tid, rdata);
  endtask

  task automatic pulse_done();
    @(negedge clk); done = 1'b1;
    @(negedge clk); done = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; add = '0; wen = 1'b1; be = '0; wdata = '0; id = '0; done = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_gnt", {31'b0, gnt}, 32'd0);
    check_val("rst_rvalid", {31'b0, r_valid}, 32'd0);
    check_val("rst_start", {31'b0, start}, 32'd0);
    check_val("rst_clear", {31'b0, clear}, 32'd0);
    check_val("rst_evt", {31'b0, evt}, 32'd0);
    check_val("rst_cfg0", cfg[31:0], 32'd0);
    rst_n = 1'b1;

    // Full-word write and read back
    bus_access(1'b0, 32'h10, 4'hF, 32'h12345678, 5'd3, rd);
    check_val("cfg0_port", cfg[31:0], 32'h12345678);
    bus_access(1'b1, 32'h10, 4'hF, 32'h0, 5'd7, rd);
    check_val("cfg0_read", rd, 32'h12345678);

    // Partial byte-enable write
    bus_access(1'b0, 32'h14, 4'hF, 32'hFFFFFFFF, 5'd1, rd);
    bus_access(1'b0, 32'h14, 4'h5, 32'h00000000, 5'd2, rd);
    bus_access(1'b1, 32'h14, 4'h0, 32'h0, 5'd4, rd);
    check_val("cfg1_bytes", rd, 32'hFF00FF00);
    check_val("cfg1_port", cfg[63:32], 32'hFF00FF00);

    // Job 1: start pulse, busy, done 9 cycles after start_o
    bus_access(1'b0, 32'h00, 4'hF, 32'h1, 5'd5, rd);
    check_val("start_pulse", {31'b0, start}, 32'd1);
    bus_access(1'b1, 32'h04, 4'h0, 32'h0, 5'd6, rd);
    check_val("status_busy", rd, 32'h00000001);
    check_val("start_gone", {31'b0, start}, 32'd0);
    repeat (7) @(posedge clk);
    #1 done = 1'b1;
    @(posedge clk); #1 done = 1'b0;
    check_val("evt_pulse", {31'b0, evt}, 32'd1);
    @(posedge clk); #1;
    check_val("evt_gone", {31'b0, evt}, 32'd0);
    bus_access(1'b1, 32'h0C, 4'h0, 32'h0, 5'd8, rd);
`ifdef SNAX_HWPE_PERIPH_PERF_EN
    check_val("perf", rd, 32'd10);
`else
    check_val("perf", rd, 32'd0);
`endif
    bus_access(1'b1, 32'h04, 4'h0, 32'h0, 5'd9, rd);
    check_val("status_done1", rd, 32'h00000100);

    // Job 2: CFG write and re-trigger while running are rejected
    bus_access(1'b0, 32'h00, 4'hF, 32'h1, 5'd10, rd);
    bus_access(1'b0, 32'h18, 4'hF, 32'hAAAA5555, 5'd11, rd);
    bus_access(1'b0, 32'h00, 4'hF, 32'h1, 5'd12, rd);
    bus_access(1'b1, 32'h04, 4'h0, 32'h0, 5'd13, rd);
    check_val("status_err_busy", rd, 32'h00000103);
    bus_access(1'b1, 32'h18, 4'h0, 32'h0, 5'd14, rd);
    check_val("cfg2_unchanged", rd, 32'h00000000);
    pulse_done();
    check_val("evt_job2", {31'b0, evt}, 32'd1);
    bus_access(1'b1, 32'h04, 4'h0, 32'h0, 5'd15, rd);
    check_val("status_done2", rd, 32'h00000202);

    // Held request: grants only every other cycle
    @(posedge clk); @(negedge clk);
    req = 1'b1; wen = 1'b1; add = 32'h04; id = 5'd9;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_val($sformatf("hold_gnt%0d", i), {31'b0, gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check_val($sformatf("hold_rvalid%0d", i), {31'b0, r_valid}, (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i % 2 == 1) check_val($sformatf("hold_rid%0d", i), {27'b0, r_id}, 32'd9);
      $display("%0t HOLD cycle=%0d gnt=%0b r_valid=%0b", $time, i, gnt, r_valid);
      @(negedge clk);
    end
    req = 1'b0;

    // Soft clear mid-run
    bus_access(1'b0, 32'h1C, 4'hF, 32'hDEADBEEF, 5'd16, rd);
    bus_access(1'b0, 32'h00, 4'hF, 32'h1, 5'd17, rd);
    bus_access(1'b0, 32'h08, 4'hF, 32'h1, 5'd18, rd);
    check_val("clear_pulse", {31'b0, clear}, 32'd1);
    bus_access(1'b1, 32'h04, 4'h0, 32'h0, 5'd19, rd);
    check_val("status_after_clear", rd, 32'h00000000);
    check_val("clear_gone", {31'b0, clear}, 32'd0);
    bus_access(1'b1, 32'h1C, 4'h0, 32'h0, 5'd20, rd);
    check_val("cfg3_cleared", rd, 32'h00000000);
    check_val("cfg0_cleared", cfg[31:0], 32'h00000000);
    check_val("cfg1_cleared", cfg[63:32], 32'h00000000);

    // Unmapped / read-only / write-only / zero byte-enable corners
    bus_access(1'b1, 32'h40, 4'h0, 32'h0, 5'd21, rd);
    check_val("oor_read", rd, 32'h00000000);
    bus_access(1'b0, 32'h04, 4'hF, 32'hFFFFFFFF, 5'd22, rd);
    bus_access(1'b0, 32'h30, 4'h0, 32'hCAFEF00D, 5'd23, rd);
    bus_access(1'b1, 32'h30, 4'h0, 32'h0, 5'd24, rd);
    check_val("cfg8_be0", rd, 32'h00000000);
    bus_access(1'b1, 32'h00, 4'h0, 32'h0, 5'd25, rd);
    check_val("trigger_reads0", rd, 32'h00000000);
    bus_access(1'b0, 32'h00, 4'h0, 32'h1, 5'd26, rd);
    check_val("trigger_be0_nostart", {31'b0, start}, 32'd0);
    pulse_done();
    check_val("done_idle_noevt", {31'b0, evt}, 32'd0);
    bus_access(1'b1, 32'h04, 4'h0, 32'h0, 5'd27, rd);
    check_val("status_ro_idle", rd, 32'h00000000);

    // Reset asserted mid-job
    bus_access(1'b0, 32'h24, 4'hF, 32'h00000055, 5'd28, rd);
    bus_access(1'b0, 32'h00, 4'hF, 32'h1, 5'd29, rd);
    @(negedge clk); rst_n = 1'b0; #1;
    check_val("midrst_start", {31'b0, start}, 32'd0);
    check_val("midrst_rvalid", {31'b0, r_valid}, 32'd0);
    check_val("midrst_cfg5", cfg[191:160], 32'd0);
    @(negedge clk); rst_n = 1'b1;
    bus_access(1'b1, 32'h04, 4'h0, 32'h0, 5'd30, rd);
    check_val("status_after_rst", rd, 32'h00000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
